// File: rtl/vend_pkg.sv
// vend_pkg: shared definitions for the vend controller.
// The controller state encoding, coin values and a strobe-count helper live here.
// The refund/change path is built only when VEND_CHANGE_EN is defined. The enum
// always contains CHANGE so that both builds share one encoding.
package vend_pkg;

   // Controller states
   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      VEND    = 2'd1,
      CHANGE  = 2'd2
   } state_e;

   // Width of a single coin value. The largest coin is 25 cents.
   localparam int COIN_W = 5;

   // Coin values in cents
   localparam logic [COIN_W-1:0] NICKEL_C  = 5'd5;
   localparam logic [COIN_W-1:0] DIME_C    = 5'd10;
   localparam logic [COIN_W-1:0] QUARTER_C = 5'd25;

   // Number of coin strobes high in the same cycle (0..3)
   function automatic logic [1:0] strobe_count(input logic n, input logic d, input logic q);
      return {1'b0, n} + {1'b0, d} + {1'b0, q};
   endfunction

endpackage

// File: rtl/coin_decode.sv
// coin_decode: combinational coin strobe decoder.
// It maps {nickel, dime, quarter} to the value of a single legal coin.
// any_coin is set when any strobe is high.
// illegal is set when more than one strobe is high (multi-hot).
module coin_decode
   import vend_pkg::*;
(
   input  logic              nickel,
   input  logic              dime,
   input  logic              quarter,
   output logic [COIN_W-1:0] value,
   output logic              any_coin,
   output logic              illegal
);

   logic [1:0] count;

   assign count    = strobe_count(nickel, dime, quarter);
   assign any_coin = (count != 2'd0);
   assign illegal  = (count > 2'd1);

   // Value of a single coin; zero when no strobe or several strobes are high
   always_comb begin
      value = '0;
      case ({nickel, dime, quarter})
         3'b100:  value = NICKEL_C;
         3'b010:  value = DIME_C;
         3'b001:  value = QUARTER_C;
         default: value = '0;
      endcase
   end

endmodule

// File: rtl/vend_change_ctrl.sv
// vend_change_ctrl: parametrised coin-operated vend controller.
// It collects nickel/dime/quarter credit up to PRICE and pulses valid for one
// cycle on purchase. It then returns any overpayment as nickel pulses.
// Illegal coin strobes are refused with a one-cycle reject pulse.
// Build option VEND_CHANGE_EN enables the CHANGE state, the change return and
// cancel/refund. When it is undefined, the excess is forfeited, cancel is
// ignored and change_nickel is tied low.
module vend_change_ctrl
   import vend_pkg::*;
#(
   parameter int PRICE = 100,
   parameter int CW    = $clog2(PRICE + 25)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          nickel,
   input  logic          dime,
   input  logic          quarter,
   input  logic          cancel,
   output logic          valid,
   output logic [CW-1:0] credit,
   output logic          change_nickel,
   output logic          reject,
   output logic          busy
);

   localparam logic [CW-1:0] PRICE_C     = CW'(PRICE);
   localparam logic [CW-1:0] NICKEL_CW_C = CW'(NICKEL_C);

   state_e          state_q, state_d;
   logic [CW-1:0]   credit_q, credit_d;
   logic            valid_q, busy_q, reject_q;
   logic            reject_d;

   logic [COIN_W-1:0] coin_value;
   logic              any_coin;
   logic              illegal;
   logic [CW-1:0]     coin_ext;
   logic [CW-1:0]     sum;
   logic              cancel_eff;

   coin_decode u_coin_decode (
      .nickel   (nickel),
      .dime     (dime),
      .quarter  (quarter),
      .value    (coin_value),
      .any_coin (any_coin),
      .illegal  (illegal)
   );

   assign coin_ext = CW'(coin_value);
   // Credit never exceeds PRICE-5 in COLLECT, so adding a quarter still fits in CW bits
   assign sum      = credit_q + coin_ext;

`ifdef VEND_CHANGE_EN
   logic          change_nickel_q;
   logic [CW-1:0] excess;

   assign cancel_eff    = cancel;
   assign excess        = credit_q - PRICE_C;
   assign change_nickel = change_nickel_q;
`else
   logic unused_cancel;

   assign unused_cancel = cancel;
   assign cancel_eff    = 1'b0;
   assign change_nickel = 1'b0;
`endif

   // Next-state, next-credit and reject decision for the current sample
   always_comb begin
      state_d  = state_q;
      credit_d = credit_q;
      reject_d = 1'b0;
      case (state_q)
         COLLECT: begin
            if (cancel_eff) begin
               // Cancel has priority over any coin sampled with it.
               // A zero-credit cancel does nothing.
               reject_d = any_coin;
               if (credit_q != '0) begin
                  state_d = CHANGE;
               end
            end else if (illegal) begin
               reject_d = 1'b1;
            end else if (any_coin) begin
               credit_d = sum;
               if (sum >= PRICE_C) begin
                  state_d = VEND;
               end
            end
         end
         VEND: begin
            reject_d = any_coin;
`ifdef VEND_CHANGE_EN
            if (excess == '0) begin
               state_d  = COLLECT;
               credit_d = '0;
            end else begin
               state_d  = CHANGE;
               credit_d = excess;
            end
`else
            state_d  = COLLECT;
            credit_d = '0;
`endif
         end
`ifdef VEND_CHANGE_EN
         CHANGE: begin
            reject_d = any_coin;
            // The nickel presented in the last change cycle empties the credit
            if (credit_q <= NICKEL_CW_C) begin
               state_d  = COLLECT;
               credit_d = '0;
            end else begin
               credit_d = credit_q - NICKEL_CW_C;
            end
         end
`endif
         default: begin
            state_d  = COLLECT;
            credit_d = '0;
         end
      endcase
   end

   // State, credit and registered outputs (outputs follow the state being entered)
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= COLLECT;
         credit_q        <= '0;
         valid_q         <= 1'b0;
         busy_q          <= 1'b0;
         reject_q        <= 1'b0;
`ifdef VEND_CHANGE_EN
         change_nickel_q <= 1'b0;
`endif
      end else begin
         state_q         <= state_d;
         credit_q        <= credit_d;
         valid_q         <= (state_d == VEND);
         busy_q          <= (state_d != COLLECT);
         reject_q        <= reject_d;
`ifdef VEND_CHANGE_EN
         change_nickel_q <= (state_d == CHANGE);
`endif
      end
   end

   assign valid  = valid_q;
   assign busy   = busy_q;
   assign reject = reject_q;
   assign credit = credit_q;

endmodule

// File: tb/tb_vend_change_ctrl.sv
// tb_vend_change_ctrl: self-checking bench for vend_change_ctrl.
// The reference model keeps the collected credit as an integer.
// A purchase or refund is modelled as a queue of the busy cycles it will produce.
// The bench follows VEND_CHANGE_EN the same way as the design.
module tb_vend_change_ctrl;

   localparam int PRICE = 100;
   localparam int CW    = $clog2(PRICE + 25);
`ifdef VEND_CHANGE_EN
   localparam bit CHG = 1'b1;
`else
   localparam bit CHG = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          nickel = 1'b0, dime = 1'b0, quarter = 1'b0, cancel = 1'b0;
   logic          valid, change_nickel, reject, busy;
   logic [CW-1:0] credit;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // One queued busy cycle: the credit shown and whether it is the vend cycle
   typedef struct {
      int cr;
      bit vend;
   } slot_t;

   slot_t         sched[$];
   int            model_cr = 0;
   logic          e_v, e_b, e_c, e_r;
   logic [CW-1:0] e_cr;

   vend_change_ctrl #(.PRICE(PRICE)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .nickel        (nickel),
      .dime          (dime),
      .quarter       (quarter),
      .cancel        (cancel),
      .valid         (valid),
      .credit        (credit),
      .change_nickel (change_nickel),
      .reject        (reject),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void model_reset();
      sched.delete();
      model_cr = 0;
      e_v = 1'b0; e_b = 1'b0; e_c = 1'b0; e_r = 1'b0; e_cr = '0;
   endfunction

   // Apply one sampled clock edge to the reference model
   function automatic void model_edge(logic n, logic d, logic q, logic c);
      int    ncoin = int'(n) + int'(d) + int'(q);
      int    val = 5 * int'(n) + 10 * int'(d) + 25 * int'(q);
      slot_t s;
      e_r = 1'b0;
      if (sched.size() > 0) begin
         e_r = (ncoin > 0);
         void'(sched.pop_front());
      end else if (CHG && c) begin
         e_r = (ncoin > 0);
         for (int v = model_cr; v > 0; v -= 5) begin
            s.cr = v; s.vend = 1'b0; sched.push_back(s);
         end
         model_cr = 0;
      end else if (ncoin > 1) begin
         e_r = 1'b1;
      end else if (ncoin == 1) begin
         model_cr += val;
         if (model_cr >= PRICE) begin
            s.cr = model_cr; s.vend = 1'b1; sched.push_back(s);
            if (CHG) begin
               for (int v = model_cr - PRICE; v > 0; v -= 5) begin
                  s.cr = v; s.vend = 1'b0; sched.push_back(s);
               end
            end
            model_cr = 0;
         end
      end
      if (sched.size() > 0) begin
         e_v = sched[0].vend; e_b = 1'b1; e_c = !sched[0].vend; e_cr = CW'(sched[0].cr);
      end else begin
         e_v = 1'b0; e_b = 1'b0; e_c = 1'b0; e_cr = CW'(model_cr);
      end
   endfunction

   // Drive one cycle of strobes {nickel,dime,quarter,cancel} and advance the model
   task automatic step(input logic [3:0] s);
      {nickel, dime, quarter, cancel} = s;
      @(posedge clk);
      model_edge(s[3], s[2], s[1], s[0]);
      #1;
      cyc++;
      $display("cyc %0d in ndqc=%b -> valid=%b busy=%b chg=%b rej=%b credit=%0d",
               cyc, s, valid, busy, change_nickel, reject, credit);
   endtask

   task automatic test_reset(input string tag);
      reset_n = 1'b0;
      {nickel, dime, quarter, cancel} = 4'b0000;
      #1;
      checks++;
      if ({valid, busy, change_nickel, reject, credit} !== '0) begin
         failures++;
         $display("FAIL %s: got v%b b%b c%b r%b credit %0d, expected all zero",
                  tag, valid, busy, change_nickel, reject, credit);
      end
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_four_quarters();
      logic [3:0] seq[$];
      int nv = 0, nc = 0;
      test_reset("reset_before_quarters");
      seq = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
      foreach (seq[i]) begin
         step(seq[i]);
         checks++;
         if ({valid, busy, change_nickel, reject, credit} !== {e_v, e_b, e_c, e_r, e_cr}) begin
            failures++;
            $display("FAIL quarters cyc %0d: got v%b b%b c%b r%b credit %0d, expected v%b b%b c%b r%b credit %0d",
                     cyc, valid, busy, change_nickel, reject, credit, e_v, e_b, e_c, e_r, e_cr);
         end
         if (valid === 1'b1) nv++;
         if (change_nickel === 1'b1) nc++;
      end
      checks++;
      if (nv != 1 || nc != 0) begin
         failures++;
         $display("FAIL quarters_counts: got valid=%0d change=%0d, expected valid=1 change=0", nv, nc);
      end
   endtask

   task automatic test_overpay();
      logic [3:0] seq[$];
      int nv = 0, nc = 0;
      test_reset("reset_before_overpay");
      seq = '{4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b0010,
              4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      foreach (seq[i]) begin
         step(seq[i]);
         checks++;
         if ({valid, busy, change_nickel, reject, credit} !== {e_v, e_b, e_c, e_r, e_cr}) begin
            failures++;
            $display("FAIL overpay cyc %0d: got v%b b%b c%b r%b credit %0d, expected v%b b%b c%b r%b credit %0d",
                     cyc, valid, busy, change_nickel, reject, credit, e_v, e_b, e_c, e_r, e_cr);
         end
         if (valid === 1'b1) nv++;
         if (change_nickel === 1'b1) nc++;
      end
      checks++;
      if (nv != 1 || nc != (CHG ? 4 : 0)) begin
         failures++;
         $display("FAIL overpay_counts: got valid=%0d change=%0d, expected valid=1 change=%0d",
                  nv, nc, CHG ? 4 : 0);
      end
   endtask

   task automatic test_multi_coin();
      logic [3:0] seq[$];
      int nr = 0;
      test_reset("reset_before_multi");
      seq = '{4'b0010, 4'b1000, 4'b1100, 4'b0000, 4'b1110, 4'b0000};
      foreach (seq[i]) begin
         step(seq[i]);
         checks++;
         if ({valid, busy, change_nickel, reject, credit} !== {e_v, e_b, e_c, e_r, e_cr}) begin
            failures++;
            $display("FAIL multi cyc %0d: got v%b b%b c%b r%b credit %0d, expected v%b b%b c%b r%b credit %0d",
                     cyc, valid, busy, change_nickel, reject, credit, e_v, e_b, e_c, e_r, e_cr);
         end
         if (reject === 1'b1) nr++;
      end
      checks++;
      if (nr != 2 || credit !== CW'(30)) begin
         failures++;
         $display("FAIL multi_counts: got rejects=%0d credit=%0d, expected rejects=2 credit=30", nr, credit);
      end
   endtask

   task automatic test_cancel();
      logic [3:0] seq[$];
      int nv = 0, nc = 0;
      test_reset("reset_before_cancel");
      seq = '{4'b0001, 4'b0100, 4'b0100, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      foreach (seq[i]) begin
         step(seq[i]);
         checks++;
         if ({valid, busy, change_nickel, reject, credit} !== {e_v, e_b, e_c, e_r, e_cr}) begin
            failures++;
            $display("FAIL cancel cyc %0d: got v%b b%b c%b r%b credit %0d, expected v%b b%b c%b r%b credit %0d",
                     cyc, valid, busy, change_nickel, reject, credit, e_v, e_b, e_c, e_r, e_cr);
         end
         if (valid === 1'b1) nv++;
         if (change_nickel === 1'b1) nc++;
      end
      checks++;
      if (nv != 0 || nc != (CHG ? 4 : 0)) begin
         failures++;
         $display("FAIL cancel_counts: got valid=%0d change=%0d, expected valid=0 change=%0d",
                  nv, nc, CHG ? 4 : 0);
      end
   endtask

   task automatic test_coin_during_change();
      logic [3:0] seq[$];
      int nc = 0, nr = 0;
      test_reset("reset_before_coin_in_change");
      seq = '{4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b0010,
              4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
      foreach (seq[i]) begin
         step(seq[i]);
         checks++;
         if ({valid, busy, change_nickel, reject, credit} !== {e_v, e_b, e_c, e_r, e_cr}) begin
            failures++;
            $display("FAIL coin_in_change cyc %0d: got v%b b%b c%b r%b credit %0d, expected v%b b%b c%b r%b credit %0d",
                     cyc, valid, busy, change_nickel, reject, credit, e_v, e_b, e_c, e_r, e_cr);
         end
         if (change_nickel === 1'b1) nc++;
         if (reject === 1'b1) nr++;
      end
      checks++;
      if (nc != (CHG ? 4 : 0) || nr != (CHG ? 1 : 0)) begin
         failures++;
         $display("FAIL coin_in_change_counts: got change=%0d rejects=%0d, expected change=%0d rejects=%0d",
                  nc, nr, CHG ? 4 : 0, CHG ? 1 : 0);
      end
   endtask

   task automatic test_reset_mid_change();
      logic [3:0] seq[$];
      test_reset("reset_before_mid_change");
      seq = '{4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b0010, 4'b0000, 4'b0000};
      foreach (seq[i]) begin
         step(seq[i]);
         checks++;
         if ({valid, busy, change_nickel, reject, credit} !== {e_v, e_b, e_c, e_r, e_cr}) begin
            failures++;
            $display("FAIL mid_change cyc %0d: got v%b b%b c%b r%b credit %0d, expected v%b b%b c%b r%b credit %0d",
                     cyc, valid, busy, change_nickel, reject, credit, e_v, e_b, e_c, e_r, e_cr);
         end
      end
      #2;
      test_reset("reset_mid_change");
      step(4'b0000);
      checks++;
      if ({valid, busy, change_nickel, reject, credit} !== '0) begin
         failures++;
         $display("FAIL after_reset_idle: got v%b b%b c%b r%b credit %0d, expected all zero",
                  valid, busy, change_nickel, reject, credit);
      end
   endtask

   task automatic test_random();
      logic [3:0] s;
      test_reset("reset_before_random");
      for (int i = 0; i < 600; i++) begin
         s[3] = ($urandom_range(0, 4) == 0);
         s[2] = ($urandom_range(0, 4) == 0);
         s[1] = ($urandom_range(0, 4) == 0);
         s[0] = ($urandom_range(0, 11) == 0);
         step(s);
         checks++;
         if ({valid, busy, change_nickel, reject, credit} !== {e_v, e_b, e_c, e_r, e_cr}) begin
            failures++;
            $display("FAIL random cyc %0d: got v%b b%b c%b r%b credit %0d, expected v%b b%b c%b r%b credit %0d",
                     cyc, valid, busy, change_nickel, reject, credit, e_v, e_b, e_c, e_r, e_cr);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset("reset");
      test_four_quarters();
      test_overpay();
      test_multi_coin();
      test_cancel();
      test_coin_during_change();
      test_reset_mid_change();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
